apb_mc_cfg_slave: RTL and testbench

- APB (v3/v4 subset) zero-wait-state slave holding the memory-controller configuration/status register file.
- Drives per-rank MRW/MRR and PPR requests, the frequency-change handshake, and an interrupt aggregated from status inputs.
- Generates a periodic MR4-read pulse from a programmable interval timer.
- Sits between the APB master port and the memory-controller core.

---
 rtl/apb_mc_cfg_pkg.sv | 30 +++
 rtl/mr4_interval_timer.sv | 42 ++++
 rtl/apb_mc_cfg_slave.sv | 163 ++++++++++++++++
 tb/tb_apb_mc_cfg_slave.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mc_cfg_pkg.sv
// Shared register map, interrupt bit positions and timer constants for the MC config slave.
package apb_mc_cfg_pkg;

    localparam int unsigned REG_W = 8;
    localparam int unsigned CNT_W = 16;

    localparam int unsigned ADDR_MRW_CMD      = 'h10;
    localparam int unsigned ADDR_MRR_CMD      = 'h11;
    localparam int unsigned ADDR_PPR_EN       = 'h12;
    localparam int unsigned ADDR_PPR_STATUS   = 'h13;
    localparam int unsigned ADDR_FREQ_CTRL    = 'h18;
    localparam int unsigned ADDR_MR4_CTRL     = 'h19;
    localparam int unsigned ADDR_INT_STATUS   = 'h20;
    localparam int unsigned ADDR_INT_MASK     = 'h21;
    localparam int unsigned ADDR_MR4_INTERVAL = 'h40;

    localparam int unsigned INT_TEST_MODE     = 0;
    localparam int unsigned INT_FREQ_ERR      = 1;
    localparam int unsigned INT_FREQ_DONE     = 2;
    localparam int unsigned INT_FREQ_READY    = 3;
    localparam int unsigned INT_WDT_TIMEOUT   = 4;
    localparam int unsigned INT_REFRESH_X_TRM = 5;
    localparam int unsigned INT_MRW_DONE      = 6;
    localparam int unsigned INT_MRR_DONE      = 7;

    localparam int unsigned FREQ_START_BIT    = 0;
    localparam int unsigned FREQ_PLL_DONE_BIT = 1;
    localparam int unsigned TIMER_DIS_BIT     = 3;

endpackage

// File: rtl/mr4_interval_timer.sv
// Reloading down-counter that emits a one-cycle pulse every interval*MR4_TICK cycles.
module mr4_interval_timer
    import apb_mc_cfg_pkg::*;
#(
    parameter int unsigned MR4_TICK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [REG_W-1:0] interval,
    input  logic             reload,
    output logic             pulse
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] reload_val;
    logic             hold;
    logic             pulse_q;

    assign reload_val = CNT_W'(CNT_W'(interval) * CNT_W'(MR4_TICK)) - CNT_W'(1);
    assign hold       = !enable || (interval == '0) || reload;
    assign pulse      = pulse_q;

    // Counter parks at its reload value while held; pulses and reloads when it reaches 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (hold) begin
                cnt_q <= reload_val;
            end else if (cnt_q == '0) begin
                cnt_q   <= reload_val;
                pulse_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/apb_mc_cfg_slave.sv
// Zero-wait APB slave holding memory-controller config/status registers and the MR4 read timer.
// Optional build macro APB_SLVERR_EN: flag unmapped accesses and PPR_STATUS writes via pslverr_o.
module apb_mc_cfg_slave
    import apb_mc_cfg_pkg::*;
#(
    parameter int unsigned APB_ADDRWIDTH = 16,
    parameter int unsigned APB_DATAWIDTH = 8,
    parameter int unsigned NB_RANK       = 2,
    parameter int unsigned MR4_TICK      = 8
) (
    input  logic                     pclk_i,
    input  logic                     prst_i,
    input  logic [APB_ADDRWIDTH-1:0] paddr_i,
    input  logic                     psel_i,
    input  logic                     penable_i,
    input  logic                     pwrite_i,
    input  logic [APB_DATAWIDTH-1:0] pwdata_i,
    input  logic [3:0]               pstrb_i,
    output logic                     pready_o,
    output logic [APB_DATAWIDTH-1:0] prdata_o,
    output logic                     pslverr_o,
    input  logic [NB_RANK-1:0]       mrw_done_status_i,
    input  logic [NB_RANK-1:0]       mrr_done_status_i,
    input  logic [NB_RANK-1:0]       ppr_done_status_i,
    input  logic [NB_RANK-1:0]       ppr_status_i,
    output logic [NB_RANK-1:0]       rank_mrw_o,
    output logic [NB_RANK-1:0]       rank_mrr_o,
    output logic [NB_RANK-1:0]       ppr_en_o,
    output logic                     start_freq_change_o,
    output logic                     pll_freq_chng_done_o,
    input  logic                     test_mode_intr_i,
    input  logic                     freq_change_error_i,
    input  logic                     freq_change_done_i,
    input  logic                     freq_change_ready_i,
    input  logic                     watch_dog_timeout_i,
    input  logic                     refresh_x_trm_i,
    output logic                     mc_intr_o,
    output logic                     mr_rd_pulse_o
);

    logic             access, wr, rd;
    logic [REG_W-1:0] wdata;
    logic             sel_mrw, sel_mrr, sel_ppr_en, sel_ppr_st, sel_freq;
    logic             sel_mr4, sel_int_st, sel_int_mask, sel_interval;

    logic [NB_RANK-1:0] rank_mrw_q, rank_mrr_q, ppr_en_q;
    logic               start_freq_q, pll_done_q, timer_dis_q, mc_intr_q;
    logic [REG_W-1:0]   int_status_q, int_mask_q, interval_q;
    logic [REG_W-1:0]   int_set, int_clr, rdata;
    logic               timer_reload;
    logic               unused_strb;

    assign access = psel_i & penable_i;
    assign wr     = access & pwrite_i & pstrb_i[0];
    assign rd     = access & ~pwrite_i;
    assign wdata  = pwdata_i[REG_W-1:0];

    assign sel_mrw      = (paddr_i == APB_ADDRWIDTH'(ADDR_MRW_CMD));
    assign sel_mrr      = (paddr_i == APB_ADDRWIDTH'(ADDR_MRR_CMD));
    assign sel_ppr_en   = (paddr_i == APB_ADDRWIDTH'(ADDR_PPR_EN));
    assign sel_ppr_st   = (paddr_i == APB_ADDRWIDTH'(ADDR_PPR_STATUS));
    assign sel_freq     = (paddr_i == APB_ADDRWIDTH'(ADDR_FREQ_CTRL));
    assign sel_mr4      = (paddr_i == APB_ADDRWIDTH'(ADDR_MR4_CTRL));
    assign sel_int_st   = (paddr_i == APB_ADDRWIDTH'(ADDR_INT_STATUS));
    assign sel_int_mask = (paddr_i == APB_ADDRWIDTH'(ADDR_INT_MASK));
    assign sel_interval = (paddr_i == APB_ADDRWIDTH'(ADDR_MR4_INTERVAL));

    assign unused_strb = ^pstrb_i[3:1];
    assign pready_o    = 1'b1;

`ifdef APB_SLVERR_EN
    logic mapped;
    assign mapped    = sel_mrw | sel_mrr | sel_ppr_en | sel_ppr_st | sel_freq |
                       sel_mr4 | sel_int_st | sel_int_mask | sel_interval;
    assign pslverr_o = access & (~mapped | (pwrite_i & sel_ppr_st));
`else
    assign pslverr_o = 1'b0;
`endif

    // Sticky event sources; bits 6/7 aggregate the per-rank mode-register completions.
    always_comb begin
        int_set                    = '0;
        int_set[INT_TEST_MODE]     = test_mode_intr_i;
        int_set[INT_FREQ_ERR]      = freq_change_error_i;
        int_set[INT_FREQ_DONE]     = freq_change_done_i;
        int_set[INT_FREQ_READY]    = freq_change_ready_i;
        int_set[INT_WDT_TIMEOUT]   = watch_dog_timeout_i;
        int_set[INT_REFRESH_X_TRM] = refresh_x_trm_i;
        int_set[INT_MRW_DONE]      = |mrw_done_status_i;
        int_set[INT_MRR_DONE]      = |mrr_done_status_i;
    end

    assign int_clr = (wr & sel_int_st) ? wdata : '0;

    // Request bits: done clears, a W1S in the same cycle wins.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            rank_mrw_q   <= '0;
            rank_mrr_q   <= '0;
            ppr_en_q     <= '0;
            start_freq_q <= 1'b0;
            pll_done_q   <= 1'b0;
            timer_dis_q  <= 1'b1;
            int_status_q <= '0;
            int_mask_q   <= '0;
            interval_q   <= '0;
            mc_intr_q    <= 1'b0;
        end else begin
            rank_mrw_q   <= (rank_mrw_q & ~mrw_done_status_i) |
                            ((wr & sel_mrw) ? wdata[NB_RANK-1:0] : '0);
            rank_mrr_q   <= (rank_mrr_q & ~mrr_done_status_i) |
                            ((wr & sel_mrr) ? wdata[NB_RANK-1:0] : '0);
            ppr_en_q     <= (ppr_en_q & ~ppr_done_status_i) |
                            ((wr & sel_ppr_en) ? wdata[NB_RANK-1:0] : '0);
            start_freq_q <= (start_freq_q & ~freq_change_done_i) |
                            (wr & sel_freq & wdata[FREQ_START_BIT]);
            pll_done_q   <= wr & sel_freq & wdata[FREQ_PLL_DONE_BIT];
            if (wr & sel_mr4)      timer_dis_q <= wdata[TIMER_DIS_BIT];
            if (wr & sel_int_mask) int_mask_q  <= wdata;
            if (wr & sel_interval) interval_q  <= wdata;
            int_status_q <= (int_status_q & ~int_clr) | int_set;
            mc_intr_q    <= |(int_status_q & int_mask_q);
        end
    end

    // Read mux; unmapped addresses read as 0.
    always_comb begin
        rdata = '0;
        if (sel_mrw)      rdata = REG_W'(rank_mrw_q);
        if (sel_mrr)      rdata = REG_W'(rank_mrr_q);
        if (sel_ppr_en)   rdata = REG_W'(ppr_en_q);
        if (sel_ppr_st)   rdata = REG_W'(ppr_status_i);
        if (sel_freq)     rdata = REG_W'(start_freq_q);
        if (sel_mr4)      rdata = REG_W'(timer_dis_q) << TIMER_DIS_BIT;
        if (sel_int_st)   rdata = int_status_q;
        if (sel_int_mask) rdata = int_mask_q;
        if (sel_interval) rdata = interval_q;
    end

    assign prdata_o = rd ? APB_DATAWIDTH'(rdata) : '0;

    // Writing TIMER_DIS=1 also reloads, so a pulse due in that very cycle is suppressed.
    assign timer_reload = wr & (sel_interval | (sel_mr4 & wdata[TIMER_DIS_BIT]));

    mr4_interval_timer #(
        .MR4_TICK (MR4_TICK)
    ) u_mr4_timer (
        .clk      (pclk_i),
        .rst      (prst_i),
        .enable   (~timer_dis_q),
        .interval (interval_q),
        .reload   (timer_reload),
        .pulse    (mr_rd_pulse_o)
    );

    assign rank_mrw_o           = rank_mrw_q;
    assign rank_mrr_o           = rank_mrr_q;
    assign ppr_en_o             = ppr_en_q;
    assign start_freq_change_o  = start_freq_q;
    assign pll_freq_chng_done_o = pll_done_q;
    assign mc_intr_o            = mc_intr_q;

endmodule

// File: tb/tb_apb_mc_cfg_slave.sv
// Directed scoreboard bench for apb_mc_cfg_slave (default parameters).
module tb_apb_mc_cfg_slave;

    logic        pclk, prst;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [7:0]  pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [7:0]  prdata;
    logic        pslverr;
    logic [1:0]  mrw_done, mrr_done, ppr_done, ppr_status;
    logic [1:0]  rank_mrw, rank_mrr, ppr_en;
    logic        start_fc, pll_done;
    logic        test_mode, fc_err, fc_done, fc_ready, wdt, refresh;
    logic        mc_intr, mr_rd_pulse;

`ifdef APB_SLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    apb_mc_cfg_slave dut (
        .pclk_i               (pclk),
        .prst_i               (prst),
        .paddr_i              (paddr),
        .psel_i               (psel),
        .penable_i            (penable),
        .pwrite_i             (pwrite),
        .pwdata_i             (pwdata),
        .pstrb_i              (pstrb),
        .pready_o             (pready),
        .prdata_o             (prdata),
        .pslverr_o            (pslverr),
        .mrw_done_status_i    (mrw_done),
        .mrr_done_status_i    (mrr_done),
        .ppr_done_status_i    (ppr_done),
        .ppr_status_i         (ppr_status),
        .rank_mrw_o           (rank_mrw),
        .rank_mrr_o           (rank_mrr),
        .ppr_en_o             (ppr_en),
        .start_freq_change_o  (start_fc),
        .pll_freq_chng_done_o (pll_done),
        .test_mode_intr_i     (test_mode),
        .freq_change_error_i  (fc_err),
        .freq_change_done_i   (fc_done),
        .freq_change_ready_i  (fc_ready),
        .watch_dog_timeout_i  (wdt),
        .refresh_x_trm_i      (refresh),
        .mc_intr_o            (mc_intr),
        .mr_rd_pulse_o        (mr_rd_pulse)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          pass_cnt = 0;
    int          check_cnt = 0;
    int          fail_cnt = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        check_cnt++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL scoreboard_empty: observed 0x%0h with no expected value", obs);
            return;
        end
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [7:0] d);
        paddr = a; pwdata = d; pwrite = 1'b1; pstrb = 4'h1; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [7:0] d, output logic err);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        #1;
        d   = prdata;
        err = pslverr;
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       e;
        expect_v(tag, 32'(exp));
        apb_read(a, d, e);
        check_pop(32'(d));
    endtask

    task automatic count_pulses(input string tag, input int cycles, input int exp);
        int n = 0;
        expect_v(tag, 32'(exp));
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (mr_rd_pulse) n++;
        end
        check_pop(32'(n));
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({rank_mrw, rank_mrr, ppr_en, start_fc, pll_done, mc_intr, mr_rd_pulse});
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       e;

        prst = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = '0; pstrb = '0;
        mrw_done = '0; mrr_done = '0; ppr_done = '0; ppr_status = '0;
        test_mode = 1'b0; fc_err = 1'b0; fc_done = 1'b0; fc_ready = 1'b0;
        wdt = 1'b0; refresh = 1'b0;
        tick(3);
        prst = 1'b0;

        // Reset state
        expect_v("reset_outputs", 32'h0);       check_pop(out_vec());
        expect_v("pready_tied", 32'h1);         check_pop(32'(pready));
        expect_v("prdata_idle", 32'h0);         check_pop(32'(prdata));
        expect_v("pslverr_idle", 32'h0);        check_pop(32'(pslverr));
        read_check("reset_mr4_ctrl", 16'h0019, 8'h08);
        read_check("reset_int_status", 16'h0020, 8'h00);
        read_check("reset_int_mask", 16'h0021, 8'h00);
        read_check("reset_interval", 16'h0040, 8'h00);

        // MR4 timer: disabled, then enabled with interval 1 (8 cycles), then disabled again
        apb_write(16'h0019, 8'h08);
        apb_write(16'h0040, 8'h01);
        count_pulses("timer_disabled", 40, 0);
        apb_write(16'h0019, 8'h00);
        for (int i = 1; i <= 24; i++) begin
            tick();
            expect_v($sformatf("timer_pulse_c%0d", i), 32'((i % 8) == 0));
            check_pop(32'(mr_rd_pulse));
        end
        apb_write(16'h0019, 8'h08);
        count_pulses("timer_redisabled", 20, 0);

        // MRW request and done
        apb_write(16'h0010, 8'h02);
        expect_v("mrw_set", 32'h2);             check_pop(32'(rank_mrw));
        read_check("mrw_readback", 16'h0010, 8'h02);
        mrw_done = 2'b10;
        tick();
        mrw_done = 2'b00;
        expect_v("mrw_cleared", 32'h0);         check_pop(32'(rank_mrw));
        read_check("int_mrw_done", 16'h0020, 8'h40);
        apb_write(16'h0020, 8'h40);
        read_check("int_w1c", 16'h0020, 8'h00);

        // MRR: done and W1S in the same cycle leave the bit set
        mrr_done = 2'b01;
        apb_write(16'h0011, 8'h01);
        mrr_done = 2'b00;
        expect_v("mrr_done_while_set", 32'h1);  check_pop(32'(rank_mrr));
        mrr_done = 2'b01;
        tick();
        mrr_done = 2'b00;
        expect_v("mrr_cleared", 32'h0);         check_pop(32'(rank_mrr));
        apb_write(16'h0020, 8'hFF);

        // PPR enable and status
        apb_write(16'h0012, 8'h03);
        expect_v("ppr_set", 32'h3);             check_pop(32'(ppr_en));
        ppr_done = 2'b01;
        tick();
        ppr_done = 2'b00;
        expect_v("ppr_partial_clear", 32'h2);   check_pop(32'(ppr_en));
        ppr_status = 2'b10;
        read_check("ppr_status", 16'h0013, 8'h02);

        // Interrupt path
        apb_write(16'h0021, 8'h10);
        wdt = 1'b1;
        tick();
        wdt = 1'b0;
        expect_v("intr_latency_0", 32'h0);      check_pop(32'(mc_intr));
        tick();
        expect_v("intr_asserted", 32'h1);       check_pop(32'(mc_intr));
        read_check("int_wdt", 16'h0020, 8'h10);
        apb_write(16'h0020, 8'h10);
        expect_v("intr_lag", 32'h1);            check_pop(32'(mc_intr));
        tick();
        expect_v("intr_cleared", 32'h0);        check_pop(32'(mc_intr));
        wdt = 1'b1;
        apb_write(16'h0020, 8'h10);
        wdt = 1'b0;
        read_check("int_set_wins", 16'h0020, 8'h10);
        apb_write(16'h0020, 8'h10);
        read_check("int_cleared_again", 16'h0020, 8'h00);

        // Frequency change handshake
        apb_write(16'h0018, 8'h01);
        expect_v("fc_start", 32'h1);            check_pop(32'(start_fc));
        tick(3);
        expect_v("fc_start_held", 32'h1);       check_pop(32'(start_fc));
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
        expect_v("fc_start_cleared", 32'h0);    check_pop(32'(start_fc));
        apb_write(16'h0018, 8'h02);
        expect_v("pll_done_pulse", 32'h1);      check_pop(32'(pll_done));
        tick();
        expect_v("pll_done_one_cycle", 32'h0);  check_pop(32'(pll_done));
        read_check("freq_ctrl_read", 16'h0018, 8'h00);

        // Unmapped access
        expect_v("unmapped_rdata", 32'h0);
        expect_v("unmapped_slverr", 32'(EXP_ERR));
        apb_read(16'h007F, d, e);
        check_pop(32'(d));
        check_pop(32'(e));

        // Reset in the middle of a timer count
        apb_write(16'h0019, 8'h00);
        apb_write(16'h0010, 8'h03);
        tick(3);
        prst = 1'b1;
        tick(2);
        prst = 1'b0;
        expect_v("midreset_outputs", 32'h0);    check_pop(out_vec());
        count_pulses("midreset_no_pulse", 20, 0);
        read_check("midreset_mr4_ctrl", 16'h0019, 8'h08);
        read_check("midreset_interval", 16'h0040, 8'h00);
        read_check("midreset_mask", 16'h0021, 8'h00);

        if (exp_q.size() != 0) begin
            check_cnt++;
            fail_cnt++;
            $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
